// File: rtl/trdb_packet_decoder_pkg.sv
// Shared types and sizing constants for the trace packet decoder.
//   PAYLOAD_LEN  : maximum payload bits per packet (multiple of 32)
//   BEAT_LEN     : input beat width in bits
//   MAX_BEATS    : payload beats in the longest packet
//   P_LEN        : width of the header byte-length field (len_bytes - 1)
//   BEAT_CNT_W   : width of the payload beat counter
// Also holds the packet format/subformat enums and the decoder FSM states.
package trdb_packet_decoder_pkg;

    localparam int PAYLOAD_LEN   = 256;
    localparam int BEAT_LEN      = 32;
    localparam int MAX_BEATS     = PAYLOAD_LEN / BEAT_LEN;
    localparam int P_LEN         = $clog2(PAYLOAD_LEN / 8);
    localparam int PKT_HDR_LEN_W = P_LEN;
    localparam int BEAT_CNT_W    = $clog2(MAX_BEATS);
    localparam int PKT_LEN_W     = P_LEN + 1;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_f_sync_subformat_e;

    typedef enum logic {
        SF_PBC = 1'b0,
        SF_JTC = 1'b1
    } trdb_f_opt_ext_subformat_e;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_PAY = 2'd1,
        S_OUT = 2'd2
    } trdb_pkt_dec_state_e;

endpackage

// File: rtl/trdb_packet_decoder_if.sv
// Bus bundle between a trace sink and the packet decoder.
//   Beat stream : beat_valid_i / beat_ready_o / beat_data_i
//   Packet out  : pkt_valid_o / pkt_ready_i plus decoded fields
//                 (format, subformat, byte length, payload, error flag)
// Signal suffixes are from the decoder's point of view.
//   slave  modport : used by the decoder
//   master modport : used by the producer/consumer side
interface trdb_packet_decoder_if;
    import trdb_packet_decoder_pkg::*;

    logic                   beat_valid_i;
    logic                   beat_ready_o;
    logic [BEAT_LEN-1:0]    beat_data_i;

    logic                   pkt_valid_o;
    logic                   pkt_ready_i;
    trdb_format_e           pkt_format_o;
    logic [1:0]             pkt_subformat_o;
    logic [PKT_LEN_W-1:0]   pkt_len_o;
    logic [PAYLOAD_LEN-1:0] pkt_payload_o;
    logic                   pkt_err_o;

    modport slave (
        input  beat_valid_i, beat_data_i, pkt_ready_i,
        output beat_ready_o, pkt_valid_o, pkt_format_o, pkt_subformat_o,
               pkt_len_o, pkt_payload_o, pkt_err_o
    );

    modport master (
        output beat_valid_i, beat_data_i, pkt_ready_i,
        input  beat_ready_o, pkt_valid_o, pkt_format_o, pkt_subformat_o,
               pkt_len_o, pkt_payload_o, pkt_err_o
    );

endinterface

// File: rtl/trdb_packet_decoder_field_decode.sv
// Combinational field decode of a reassembled trace packet.
//   payload_lo_i : first four payload bits (format + subformat bits)
//   len_bytes_i  : payload length in bytes
//   hdr_err_i    : header reserved-bit error from the framer
//   format_o     : packet format
//   subformat_o  : subformat (zero-extended for F_OPT_EXT, 0 for formats 1/2)
//   err_o        : header error or an F_SYNC packet too short for its subformat
module trdb_pkt_field_decode
    import trdb_packet_decoder_pkg::*;
(
    input  logic [3:0]           payload_lo_i,
    input  logic [PKT_LEN_W-1:0] len_bytes_i,
    input  logic                 hdr_err_i,
    output trdb_format_e         format_o,
    output logic [1:0]           subformat_o,
    output logic                 err_o
);

    always_comb begin
        format_o    = trdb_format_e'(payload_lo_i[1:0]);
        subformat_o = 2'b00;
        unique case (format_o)
            F_SYNC:    subformat_o = payload_lo_i[3:2];
            F_OPT_EXT: subformat_o = {1'b0, payload_lo_i[2]};
            default:   subformat_o = 2'b00;
        endcase
        // A one-byte sync packet is flagged to mirror the encoder's minimum size.
        err_o = hdr_err_i ||
                ((format_o == F_SYNC) && (len_bytes_i == PKT_LEN_W'(1)));
    end

endmodule

// File: rtl/trdb_packet_decoder.sv
// Receive-side trace packet decoder.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous abort of the packet in progress (beats offered in
//             the same cycle are not consumed)
//   bus     : beat stream in, decoded packet out (slave modport)
// One header beat (byte length - 1 in the low bits, reserved bits above it)
// is followed by ceil(len/4) little-endian payload beats. The decoded packet
// is held on the output until accepted.
module trdb_packet_decoder
    import trdb_packet_decoder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    trdb_packet_decoder_if.slave bus
);

    localparam int BYTES_PER_BEAT = BEAT_LEN / 8;

    trdb_pkt_dec_state_e                       state_q;
    logic [P_LEN-1:0]                          len_field_q;
    logic [PKT_LEN_W-1:0]                      len_bytes_q;
    logic [BEAT_CNT_W-1:0]                     cnt_q;
    logic                                      hdr_err_q;
    logic                                      beat_ready_q;
    logic                                      pkt_valid_q;
    logic [MAX_BEATS-1:0][BEAT_LEN-1:0]        buf_q;

    logic [BEAT_LEN-1:0]                       beat_masked;
    logic [BEAT_CNT_W-1:0]                     last_idx;
    logic                                      beat_fire;
    logic                                      pkt_fire;

    // Index of the final payload beat: ceil(len/4)-1 == (len-1)/4.
    assign last_idx  = len_field_q[P_LEN-1:2];
    assign beat_fire = bus.beat_valid_i && beat_ready_q;
    assign pkt_fire  = pkt_valid_q && bus.pkt_ready_i;

    // Zero every byte lying beyond the packet length so padding never
    // reaches the payload output.
    generate
        for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_mask
            logic [PKT_LEN_W-1:0] byte_idx;
            assign byte_idx = PKT_LEN_W'({cnt_q, 2'(gi)});
            assign beat_masked[8*gi +: 8] = (byte_idx < len_bytes_q) ?
                                            bus.beat_data_i[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_HDR;
            len_field_q  <= '0;
            len_bytes_q  <= '0;
            cnt_q        <= '0;
            hdr_err_q    <= 1'b0;
            beat_ready_q <= 1'b1;
            pkt_valid_q  <= 1'b0;
            buf_q        <= '0;
        end else if (flush_i) begin
            // Flush wins over any handshake in the same cycle.
            state_q      <= S_HDR;
            cnt_q        <= '0;
            beat_ready_q <= 1'b1;
            pkt_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_HDR: begin
                    if (beat_fire) begin
                        len_field_q <= bus.beat_data_i[P_LEN-1:0];
                        len_bytes_q <= PKT_LEN_W'(bus.beat_data_i[P_LEN-1:0]) +
                                       PKT_LEN_W'(1);
                        hdr_err_q   <= |bus.beat_data_i[7:P_LEN];
                        cnt_q       <= '0;
                        buf_q       <= '0;
                        state_q     <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (beat_fire) begin
                        buf_q[cnt_q] <= beat_masked;
                        cnt_q        <= cnt_q + BEAT_CNT_W'(1);
                        if (cnt_q == last_idx) begin
                            state_q      <= S_OUT;
                            beat_ready_q <= 1'b0;
                            pkt_valid_q  <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (pkt_fire) begin
                        state_q      <= S_HDR;
                        beat_ready_q <= 1'b1;
                        pkt_valid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_HDR;
                    beat_ready_q <= 1'b1;
                    pkt_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.beat_ready_o  = beat_ready_q;
    assign bus.pkt_valid_o   = pkt_valid_q;
    assign bus.pkt_len_o     = len_bytes_q;
    assign bus.pkt_payload_o = buf_q;

    trdb_pkt_field_decode u_field_decode (
        .payload_lo_i (buf_q[0][3:0]),
        .len_bytes_i  (len_bytes_q),
        .hdr_err_i    (hdr_err_q),
        .format_o     (bus.pkt_format_o),
        .subformat_o  (bus.pkt_subformat_o),
        .err_o        (bus.pkt_err_o)
    );

endmodule

// File: tb/tb_trdb_packet_decoder.sv
module tb_trdb_packet_decoder;
    import trdb_packet_decoder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] bt [8];

    always #5 clk = ~clk;

    trdb_packet_decoder_if bus ();

    trdb_packet_decoder dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"},   bus.pkt_valid_o, 0);
        chk({tag, " format"},  bus.pkt_format_o, 0);
        chk({tag, " subfmt"},  bus.pkt_subformat_o, 0);
        chk({tag, " len"},     bus.pkt_len_o, 0);
        chk({tag, " payload"}, bus.pkt_payload_o, 0);
        chk({tag, " err"},     bus.pkt_err_o, 0);
    endtask

    // Offer one beat from a negedge and let it be taken on the next posedge.
    task automatic drive_beat(input logic [31:0] d, input string tag);
        int t;
        @(negedge clk);
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = d;
        t = 0;
        while (!bus.beat_ready_o && t < 16) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " beat_ready"}, bus.beat_ready_o, 1);
        chk({tag, " valid_low"},  bus.pkt_valid_o, 0);
        @(posedge clk);
    endtask

    // Send header + payload from bt[], compare against a byte-level model,
    // hold the packet for 'hold' cycles, then accept it.
    task automatic run_packet(input logic [31:0] hdr, input int hold, input string tag);
        int           len_b;
        int           nb;
        int           t;
        logic [255:0] ep;
        logic [1:0]   ef;
        logic [1:0]   es;
        logic         ee;
        len_b = int'(hdr[4:0]) + 1;
        nb    = (len_b + 3) / 4;
        ep    = '0;
        for (int b = 0; b < len_b; b++)
            ep[8*b +: 8] = bt[b/4][8*(b%4) +: 8];
        ef = ep[1:0];
        if (ef == 2'd3)      es = ep[3:2];
        else if (ef == 2'd0) es = {1'b0, ep[2]};
        else                 es = 2'd0;
        ee = (hdr[7:5] != 3'd0) || (ef == 2'd3 && len_b == 1);

        drive_beat(hdr, {tag, " hdr"});
        for (int k = 0; k < nb; k++)
            drive_beat(bt[k], {tag, " pay"});
        @(negedge clk);
        bus.beat_valid_i = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk({tag, " valid"},      bus.pkt_valid_o, 1);
            chk({tag, " beat_ready"}, bus.beat_ready_o, 0);
            chk({tag, " format"},     bus.pkt_format_o, ef);
            chk({tag, " subfmt"},     bus.pkt_subformat_o, es);
            chk({tag, " len"},        bus.pkt_len_o, len_b);
            chk({tag, " payload"},    bus.pkt_payload_o, ep);
            chk({tag, " err"},        bus.pkt_err_o, ee);
        end
        bus.pkt_ready_i = 1'b1;
        t = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end while (bus.pkt_valid_o && t < 16);
        chk({tag, " accepted"},   bus.pkt_valid_o, 0);
        chk({tag, " ready_back"}, bus.beat_ready_o, 1);
        bus.pkt_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] hdr;
        bus.beat_valid_i = 1'b0;
        bus.beat_data_i  = '0;
        bus.pkt_ready_i  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_por");
        chk("after_por beat_ready", bus.beat_ready_o, 1);

        // Directed packets
        bt = '{32'hDEAD_BEE3, 0, 0, 0, 0, 0, 0, 0};
        run_packet(32'h0000_0003, 0, "sync4");
        bt = '{32'h1122_3346, 32'hFFFF_5566, 0, 0, 0, 0, 0, 0};
        run_packet(32'h0000_0005, 1, "addr6");
        for (int i = 0; i < 8; i++) bt[i] = 32'hA5A5_A5A4;
        run_packet(32'h0000_001F, 5, "full32");
        bt = '{32'h1234_5676, 0, 0, 0, 0, 0, 0, 0};
        run_packet(32'h0000_0020, 0, "resv_err");
        bt = '{32'hFFFF_FF0F, 0, 0, 0, 0, 0, 0, 0};
        run_packet(32'h0000_0000, 0, "sync_len1");

        // Flush on the second payload beat of a three-beat packet
        drive_beat(32'h0000_000B, "flush hdr");
        drive_beat(32'h0102_0304, "flush pay0");
        @(negedge clk);
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = 32'h0000_0001;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        bus.beat_valid_i = 1'b0;
        chk("flush valid", bus.pkt_valid_o, 0);
        chk("flush beat_ready", bus.beat_ready_o, 1);
        @(negedge clk);
        chk("flush valid_later", bus.pkt_valid_o, 0);
        bt = '{32'h7766_5541, 32'hCCBB_AA99, 0, 0, 0, 0, 0, 0};
        run_packet(32'h0000_0007, 0, "post_flush");

        // Reset in the middle of the payload
        drive_beat(32'h0000_000B, "rst hdr");
        drive_beat(32'h0A0B_0C0D, "rst pay0");
        @(negedge clk);
        bus.beat_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst_rel");
        chk("mid_rst_rel beat_ready", bus.beat_ready_o, 1);
        bt = '{32'h4433_2210, 32'h8877_6655, 32'hCCBB_AA99, 0, 0, 0, 0, 0};
        run_packet(32'h0000_000B, 2, "post_rst");

        // Randomised packets
        for (int n = 0; n < 30; n++) begin
            r   = $urandom();
            hdr = r;
            if ($urandom_range(0, 5) == 0) hdr[7:5] = 3'($urandom_range(1, 7));
            else                           hdr[7:5] = 3'b000;
            for (int i = 0; i < 8; i++) bt[i] = $urandom();
            run_packet(hdr, int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
